// File: rtl/i2c_cfg_responder.sv
// i2c_cfg_responder
// I2C target that fronts a 256-entry, 8-bit configuration register file.
// A write transaction sets the register pointer and then writes data bytes.
// A read transaction streams bytes out starting at the current pointer. The
// pointer auto-increments and wraps.
//
// Ports
//   CLK       in   system clock; everything is on its rising edge
//   RESET     in   synchronous active-high reset
//   SCL_IN    in   I2C clock from the configuration master (asynchronous)
//   SDA_IN    in   I2C data line as seen on the bus (asynchronous)
//   SDA_OUT   out  open-drain drive: 0 pulls the line low, 1 releases it
//   WR_STB    out  one-CLK pulse for each accepted data byte
//   WR_ADDR   out  register pointer of the byte being written
//   WR_DATA   out  data byte being written
//   DBG_ADDR  in   register-file read address for a host or bench
//   DBG_DATA  out  registered register-file contents at DBG_ADDR (1 CLK)
//   BUSY      out  high from an address-matched START until STOP
module i2c_cfg_responder #(
  parameter logic [6:0] SLAVE_ADDR = 7'h76,
  parameter logic [7:0] INIT_VAL   = 8'h00
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       SCL_IN,
  input  logic       SDA_IN,
  output logic       SDA_OUT,
  output logic       WR_STB,
  output logic [7:0] WR_ADDR,
  output logic [7:0] WR_DATA,
  input  logic [7:0] DBG_ADDR,
  output logic [7:0] DBG_DATA,
  output logic       BUSY
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;

  // ---------------------------------------------------------------------
  // Bus input synchronisers. Bit 0 carries SCL and bit 1 carries SDA.
  // prev_q holds the previous synchronised value for edge detection, so a
  // bus event produces a registered reaction on the third CLK edge.
  // ---------------------------------------------------------------------
  logic [1:0] bus_raw;
  logic [1:0] sync1_q, sync2_q, prev_q;

  assign bus_raw = {SDA_IN, SCL_IN};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      always_ff @(posedge CLK) begin
        if (RESET) begin
          sync1_q[gi] <= 1'b1;
          sync2_q[gi] <= 1'b1;
          prev_q[gi]  <= 1'b1;
        end else begin
          sync1_q[gi] <= bus_raw[gi];
          sync2_q[gi] <= sync1_q[gi];
          prev_q[gi]  <= sync2_q[gi];
        end
      end
    end
  endgenerate

  logic scl_s, sda_s, scl_p, sda_p;
  logic scl_rise, scl_fall, start_det, stop_det;

  assign scl_s = sync2_q[0];
  assign sda_s = sync2_q[1];
  assign scl_p = prev_q[0];
  assign sda_p = prev_q[1];

  assign scl_rise  = scl_s & ~scl_p;
  assign scl_fall  = ~scl_s & scl_p;
  // START and STOP need SCL high on both samples. This keeps a data change
  // that arrives together with an SCL edge from being mistaken for one.
  assign start_det = scl_s & scl_p & sda_p & ~sda_s;
  assign stop_det  = scl_s & scl_p & ~sda_p & sda_s;

  // ---------------------------------------------------------------------
  // Register file. It has one write port, driven by the registered write
  // strobe. It has two registered read ports: one for the debug/host
  // address and one that follows the pointer for read transactions.
  // ---------------------------------------------------------------------
  logic [7:0] mem_q [256];
  logic [7:0] dbg_data_q, rd_data_q;

  logic [7:0] ptr_q;
  logic       wr_stb_q;
  logic [7:0] wr_addr_q, wr_data_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < 256; i++) begin
        mem_q[i] <= INIT_VAL;
      end
    end else if (wr_stb_q) begin
      mem_q[wr_addr_q] <= wr_data_q;
    end
  end

  // The read ports sample the array before this edge's write lands. A
  // same-address read therefore returns the old contents.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      dbg_data_q <= INIT_VAL;
      rd_data_q  <= INIT_VAL;
    end else begin
      dbg_data_q <= mem_q[DBG_ADDR];
      rd_data_q  <= mem_q[ptr_q];
    end
  end

  // ---------------------------------------------------------------------
  // Protocol FSM
  // ---------------------------------------------------------------------
  state_t     state_q;
  logic [3:0] bit_cnt_q;
  logic [7:0] shift_q, tx_q;
  logic       sda_out_q, busy_q, rw_q;
  logic [7:0] shift_d;

  assign shift_d = {shift_q[6:0], sda_s};

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      bit_cnt_q <= 4'd0;
      shift_q   <= 8'h00;
      tx_q      <= 8'hFF;
      sda_out_q <= 1'b1;
      busy_q    <= 1'b0;
      rw_q      <= 1'b0;
      ptr_q     <= 8'h00;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= 8'h00;
      wr_data_q <= 8'h00;
    end else begin
      wr_stb_q <= 1'b0;
      if (stop_det) begin
        state_q   <= IDLE;
        sda_out_q <= 1'b1;
        busy_q    <= 1'b0;
        bit_cnt_q <= 4'd0;
      end else if (start_det) begin
        // This covers both a plain START and a repeated START. BUSY is kept
        // through a repeated START and is re-decided at the address ACK.
        state_q   <= ADDR;
        sda_out_q <= 1'b1;
        bit_cnt_q <= 4'd0;
      end else begin
        case (state_q)
          ADDR, PTR, WDATA: begin
            if (scl_rise && bit_cnt_q != 4'd8) begin
              shift_q   <= shift_d;
              bit_cnt_q <= bit_cnt_q + 4'd1;
              // The data byte is committed on the rising edge of bit 8,
              // ahead of its ACK.
              if (state_q == WDATA && bit_cnt_q == 4'd7) begin
                wr_stb_q  <= 1'b1;
                wr_addr_q <= ptr_q;
                wr_data_q <= shift_d;
                ptr_q     <= ptr_q + 8'd1;
              end
            end else if (scl_fall && bit_cnt_q == 4'd8) begin
              bit_cnt_q <= 4'd0;
              case (state_q)
                ADDR: begin
                  if (shift_q[7:1] == SLAVE_ADDR) begin
                    state_q   <= ADDR_ACK;
                    sda_out_q <= 1'b0;
                    busy_q    <= 1'b1;
                    rw_q      <= shift_q[0];
                  end else begin
                    state_q   <= IGNORE;
                    sda_out_q <= 1'b1;
                    busy_q    <= 1'b0;
                  end
                end
                PTR: begin
                  ptr_q     <= shift_q;
                  state_q   <= PTR_ACK;
                  sda_out_q <= 1'b0;
                end
                default: begin
                  state_q   <= WDATA_ACK;
                  sda_out_q <= 1'b0;
                end
              endcase
            end
          end

          ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt_q <= 4'd0;
              if (rw_q) begin
                // The falling edge that ends the ACK also presents the
                // first read bit.
                state_q   <= RDATA;
                sda_out_q <= rd_data_q[7];
                tx_q      <= {rd_data_q[6:0], 1'b1};
              end else begin
                state_q   <= PTR;
                sda_out_q <= 1'b1;
              end
            end
          end

          PTR_ACK, WDATA_ACK: begin
            if (scl_fall) begin
              state_q   <= WDATA;
              sda_out_q <= 1'b1;
              bit_cnt_q <= 4'd0;
            end
          end

          RDATA: begin
            if (scl_rise && bit_cnt_q != 4'd8) begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt_q == 4'd8) begin
                state_q   <= RDATA_ACK;
                sda_out_q <= 1'b1;
                bit_cnt_q <= 4'd0;
                ptr_q     <= ptr_q + 8'd1;
              end else begin
                sda_out_q <= tx_q[7];
                tx_q      <= {tx_q[6:0], 1'b1};
              end
            end
          end

          RDATA_ACK: begin
            // A NACK leaves on the rising edge. After an ACK, the next
            // falling edge starts the following byte from the already
            // advanced pointer.
            if (scl_rise && sda_s) begin
              state_q <= IGNORE;
            end else if (scl_fall) begin
              state_q   <= RDATA;
              bit_cnt_q <= 4'd0;
              sda_out_q <= rd_data_q[7];
              tx_q      <= {rd_data_q[6:0], 1'b1};
            end
          end

          default: begin
            // IDLE and IGNORE wait for START or STOP with SDA released.
            sda_out_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign SDA_OUT  = sda_out_q;
  assign WR_STB   = wr_stb_q;
  assign WR_ADDR  = wr_addr_q;
  assign WR_DATA  = wr_data_q;
  assign DBG_DATA = dbg_data_q;
  assign BUSY     = busy_q;

endmodule
